// File: rtl/player_pkg.sv
// Shared types and constants for the song player: note/octave codes, field widths
// and the sequencer FSM state encoding.
package player_pkg;

  localparam int NOTE_W = 4;
  localparam int DUR_W  = 4;
  localparam int OCT_W  = 2;

  localparam logic [NOTE_W-1:0] NOTE_REST = 4'h0;
  localparam logic [NOTE_W-1:0] NOTE_PAD  = 4'hF;

  localparam logic [OCT_W-1:0] OCT_MID  = 2'b00;
  localparam logic [OCT_W-1:0] OCT_LOW  = 2'b01;
  localparam logic [OCT_W-1:0] OCT_HIGH = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_e;

  // A zero-length entry still lasts one duration unit.
  function automatic logic [DUR_W-1:0] dur_units(input logic [DUR_W-1:0] d);
    return (d == 4'd0) ? 4'd1 : d;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Duration-unit timebase: counts TICK_DIV enabled cycles and flags the wrap with a
// one-cycle tick. clr restarts the unit and suppresses the tick.
module tick_prescaler #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] CNT_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt_r;

  // Prescaler counter: advances only while enabled, wraps at CNT_MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {PW{1'b0}};
    end else if (clr) begin
      cnt_r <= {PW{1'b0}};
    end else if (en) begin
      if (cnt_r == CNT_MAX) begin
        cnt_r <= {PW{1'b0}};
      end else begin
        cnt_r <= cnt_r + PW'(1);
      end
    end
  end

  assign tick = en && !clr && (cnt_r == CNT_MAX);

endmodule

// File: rtl/note_sequencer.sv
// Steps through a snapshot of one song (NOTES entries of note/duration/octave) and
// presents each entry for its duration. Build option: SEQ_SKIP_PAD_EN skips 4'hF entries.
module note_sequencer
  import player_pkg::*;
#(
  parameter int NOTES    = 56,
  parameter int TICK_DIV = 25_000_000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NOTES*NOTE_W-1:0]   song_packed,
  input  logic [NOTES*DUR_W-1:0]    time_continue,
  input  logic [NOTES*OCT_W-1:0]    octave_packed,
  input  logic                      start,
  input  logic                      pause,
  input  logic                      stop,
  output logic [NOTE_W-1:0]         note,
  output logic [OCT_W-1:0]          octave,
  output logic [5:0]                note_idx,
  output logic                      note_strobe,
  output logic                      playing,
  output logic                      done
);

  localparam int SONG_W = NOTES * NOTE_W;
  localparam int DURV_W = NOTES * DUR_W;
  localparam int OCTV_W = NOTES * OCT_W;
  localparam logic [5:0] LAST_IDX = 6'(NOTES - 1);

  seq_state_e          state_r;
  logic [SONG_W-1:0]   song_r;
  logic [DURV_W-1:0]   dur_r;
  logic [OCTV_W-1:0]   oct_r;
  logic [5:0]          idx_r;
  logic [DUR_W-1:0]    units_r;
  logic [NOTE_W-1:0]   cur_note_r;

  logic [NOTE_W-1:0]   song_tab_s [NOTES];
  logic [DUR_W-1:0]    dur_tab_s  [NOTES];
  logic [OCT_W-1:0]    oct_tab_s  [NOTES];
  logic [NOTE_W-1:0]   ent_note_s;
  logic [DUR_W-1:0]    ent_dur_s;
  logic [OCT_W-1:0]    ent_oct_s;
  logic                launch_s;
  logic                run_s;
  logic                pad_s;
  logic                tick_s;

  // Entry 0 sits in the most significant field of each packed vector.
  for (genvar g = 0; g < NOTES; g++) begin : g_tab
    assign song_tab_s[g] = song_r[SONG_W-1-NOTE_W*g -: NOTE_W];
    assign dur_tab_s[g]  = dur_r[DURV_W-1-DUR_W*g -: DUR_W];
    assign oct_tab_s[g]  = oct_r[OCTV_W-1-OCT_W*g -: OCT_W];
  end

  // Current-entry lookup and the qualifiers that drive the FSM and timebase.
  always_comb begin
    ent_note_s = song_tab_s[idx_r];
    ent_dur_s  = dur_tab_s[idx_r];
    ent_oct_s  = oct_tab_s[idx_r];
    launch_s   = ((state_r == ST_IDLE) || (state_r == ST_DONE)) && start && !stop;
    // The release cycle out of PAUSE already counts as playback time.
    run_s      = ((state_r == ST_PLAY) || (state_r == ST_PAUSE)) && !pause && !stop;
`ifdef SEQ_SKIP_PAD_EN
    pad_s      = (ent_note_s == NOTE_PAD);
`else
    pad_s      = 1'b0;
`endif
  end

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (run_s),
    .clr   (state_r == ST_LOAD),
    .tick  (tick_s)
  );

  // Snapshot registers: later input changes never disturb the song being played.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      song_r <= {SONG_W{1'b0}};
      dur_r  <= {DURV_W{1'b0}};
      oct_r  <= {OCTV_W{1'b0}};
    end else if (launch_s) begin
      song_r <= song_packed;
      dur_r  <= time_continue;
      oct_r  <= octave_packed;
    end
  end

  // Sequencer FSM with registered outputs; stop outranks start, pause outranks a wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      idx_r       <= 6'd0;
      units_r     <= 4'd0;
      cur_note_r  <= NOTE_REST;
      note        <= NOTE_REST;
      octave      <= OCT_MID;
      note_idx    <= 6'd0;
      note_strobe <= 1'b0;
      playing     <= 1'b0;
      done        <= 1'b0;
    end else if (stop) begin
      state_r     <= ST_IDLE;
      idx_r       <= 6'd0;
      units_r     <= 4'd0;
      cur_note_r  <= NOTE_REST;
      note        <= NOTE_REST;
      octave      <= OCT_MID;
      note_idx    <= 6'd0;
      note_strobe <= 1'b0;
      playing     <= 1'b0;
      done        <= 1'b0;
    end else begin
      note_strobe <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            idx_r   <= 6'd0;
            done    <= 1'b0;
            state_r <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (pad_s) begin
            if (idx_r == LAST_IDX) begin
              state_r <= ST_DONE;
              done    <= 1'b1;
              note    <= NOTE_REST;
            end else begin
              idx_r <= idx_r + 6'd1;
            end
          end else begin
            note        <= ent_note_s;
            cur_note_r  <= ent_note_s;
            octave      <= ent_oct_s;
            note_idx    <= idx_r;
            note_strobe <= 1'b1;
            units_r     <= dur_units(ent_dur_s);
            playing     <= 1'b1;
            state_r     <= ST_PLAY;
          end
        end
        ST_PLAY, ST_PAUSE: begin
          if (pause) begin
            state_r <= ST_PAUSE;
            note    <= NOTE_REST;
            playing <= 1'b0;
          end else if (tick_s && (units_r == 4'd1)) begin
            playing <= 1'b0;
            if (idx_r == LAST_IDX) begin
              state_r <= ST_DONE;
              done    <= 1'b1;
              note    <= NOTE_REST;
            end else begin
              idx_r   <= idx_r + 6'd1;
              note    <= cur_note_r;
              state_r <= ST_LOAD;
            end
          end else begin
            if (tick_s) begin
              units_r <= units_r - 4'd1;
            end
            note    <= cur_note_r;
            playing <= 1'b1;
            state_r <= ST_PLAY;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer (TICK_DIV=2): an entry-timeline reference model checked every
// cycle, plus directed scenarios with hand-computed timing and values.
module tb_note_sequencer;

  localparam int TD = 2;
  localparam int N  = 56;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0, pause = 1'b0, stop = 1'b0;
  logic [223:0] song_packed = '0, time_continue = '0;
  logic [111:0] octave_packed = '0;
  logic [3:0]   note;
  logic [1:0]   octave;
  logic [5:0]   note_idx;
  logic         note_strobe, playing, done;

  int total = 0, bad = 0, cyc = 0, t0 = 0, r = 0, strobes = 0, s0 = 0;
  bit chk_en = 1'b0;

  note_sequencer #(.NOTES(N), .TICK_DIV(TD)) dut (
    .clk(clk), .rst_n(rst_n), .song_packed(song_packed), .time_continue(time_continue),
    .octave_packed(octave_packed), .start(start), .pause(pause), .stop(stop),
    .note(note), .octave(octave), .note_idx(note_idx), .note_strobe(note_strobe),
    .playing(playing), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (note_strobe === 1'b1) strobes <= strobes + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: whole entries measured in cycles ----------------
  logic [3:0] ma_note [N];
  logic [3:0] ma_dur  [N];
  logic [1:0] ma_oct  [N];
  int         m_phase, m_pos, m_i;   // phase 0 idle, 1 running, 2 finished
  logic [3:0] m_note;
  logic [1:0] m_oct;
  logic [5:0] m_idx;
  logic       m_strobe, m_playing, m_done;

  function automatic int ent_len(input int i);
    int d;
    d = int'(ma_dur[i]);
    if (d == 0) d = 1;
    return 1 + d * TD;
  endfunction

  function automatic bit is_pad(input int i);
`ifdef SEQ_SKIP_PAD_EN
    return ma_note[i] == 4'hF;
`else
    return (i < 0);
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || stop) begin
      m_phase <= 0; m_pos <= 0; m_i <= 0;
      m_note <= 4'd0; m_oct <= 2'd0; m_idx <= 6'd0;
      m_strobe <= 1'b0; m_playing <= 1'b0; m_done <= 1'b0;
    end else if (m_phase != 1) begin
      m_strobe <= 1'b0;
      if (start) begin
        for (int i = 0; i < N; i++) begin
          ma_note[i] <= song_packed[223-4*i -: 4];
          ma_dur[i]  <= time_continue[223-4*i -: 4];
          ma_oct[i]  <= octave_packed[111-2*i -: 2];
        end
        m_phase <= 1; m_pos <= 0; m_i <= 0; m_done <= 1'b0;
      end
    end else begin
      m_strobe <= 1'b0;
      if (m_pos == 0) begin
        if (is_pad(m_i)) begin
          if (m_i == N-1) begin
            m_phase <= 2; m_done <= 1'b1; m_note <= 4'd0;
          end else begin
            m_i <= m_i + 1;
          end
        end else begin
          m_note <= ma_note[m_i]; m_oct <= ma_oct[m_i]; m_idx <= 6'(m_i);
          m_strobe <= 1'b1; m_playing <= 1'b1; m_pos <= 1;
        end
      end else if (pause) begin
        m_note <= 4'd0; m_playing <= 1'b0;
      end else if (m_pos + 1 == ent_len(m_i)) begin
        m_playing <= 1'b0;
        if (m_i == N-1) begin
          m_phase <= 2; m_done <= 1'b1; m_note <= 4'd0;
        end else begin
          m_i <= m_i + 1; m_pos <= 0; m_note <= ma_note[m_i];
        end
      end else begin
        m_pos <= m_pos + 1; m_note <= ma_note[m_i]; m_playing <= 1'b1;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_note", 32'(note), 32'(m_note));
      chk("m_octave", 32'(octave), 32'(m_oct));
      chk("m_note_idx", 32'(note_idx), 32'(m_idx));
      chk("m_strobe", 32'(note_strobe), 32'(m_strobe));
      chk("m_playing", 32'(playing), 32'(m_playing));
      chk("m_done", 32'(done), 32'(m_done));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_entry(input int i, input logic [3:0] n, input logic [3:0] d, input logic [1:0] o);
    song_packed[223-4*i -: 4]   = n;
    time_continue[223-4*i -: 4] = d;
    octave_packed[111-2*i -: 2] = o;
  endtask

  task automatic fill(input logic [3:0] n, input logic [3:0] d, input logic [1:0] o);
    for (int i = 0; i < N; i++) set_entry(i, n, d, o);
  endtask

  task automatic go();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; t0 = cyc;
  endtask

  // which: 0 = next note_strobe, 1 = done high. rel is edges since the start edge.
  task automatic wait_ev(input int which, input int budget, input string name, output int rel);
    rel = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if ((which == 0 && note_strobe === 1'b1) || (which == 1 && done === 1'b1)) begin
        rel = cyc - t0;
        break;
      end
    end
    if (rel < 0) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic do_stop();
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    fill(4'd1, 4'd3, 2'd0);
    repeat (3) @(negedge clk);
    chk("rst_note", 32'(note), 32'd0);
    chk("rst_octave", 32'(octave), 32'd0);
    chk("rst_idx", 32'(note_idx), 32'd0);
    chk("rst_strobe", 32'(note_strobe), 32'd0);
    chk("rst_playing", 32'(playing), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Basic: 56 x (1 + 3*2) cycles
    go(); s0 = strobes;
    wait_ev(0, 20, "t1_s0", r);
    chk("t1_first_strobe", 32'(r), 32'd1);
    chk("t1_first_note", 32'(note), 32'd1);
    chk("t1_first_idx", 32'(note_idx), 32'd0);
    wait_ev(0, 20, "t1_s1", r);
    chk("t1_second_strobe", 32'(r), 32'd8);
    chk("t1_second_idx", 32'(note_idx), 32'd1);
    wait_ev(1, 500, "t1_done", r);
    chk("t1_done_time", 32'(r), 32'd392);
    chk("t1_strobe_count", 32'(strobes - s0), 32'd56);
    chk("t1_last_idx", 32'(note_idx), 32'd55);
    chk("t1_done_note", 32'(note), 32'd0);

    // Zero duration rest, then note 5 octave 01 for one unit
    fill(4'd1, 4'd1, 2'd0);
    set_entry(0, 4'd0, 4'd0, 2'd0);
    set_entry(1, 4'd5, 4'd1, 2'd1);
    go();
    wait_ev(0, 20, "t2_s0", r);
    chk("t2_first_strobe", 32'(r), 32'd1);
    chk("t2_rest_note", 32'(note), 32'd0);
    wait_ev(0, 20, "t2_s1", r);
    chk("t2_second_strobe", 32'(r), 32'd4);
    chk("t2_note5", 32'(note), 32'd5);
    chk("t2_oct1", 32'(octave), 32'd1);
    repeat (2) @(negedge clk);
    chk("t2_note5_held", 32'(note), 32'd5);
    wait_ev(0, 20, "t2_s2", r);
    chk("t2_third_strobe", 32'(r), 32'd7);

    // Stop together with start and pause
    @(negedge clk); stop = 1'b1; start = 1'b1; pause = 1'b1;
    @(negedge clk); stop = 1'b0; start = 1'b0; pause = 1'b0;
    chk("t4_stop_note", 32'(note), 32'd0);
    chk("t4_stop_oct", 32'(octave), 32'd0);
    chk("t4_stop_idx", 32'(note_idx), 32'd0);
    chk("t4_stop_playing", 32'(playing), 32'd0);
    repeat (5) @(negedge clk);
    chk("t4_still_idle", 32'(playing), 32'd0);

    // Pause for 10 cycles during entry 1
    fill(4'd1, 4'd3, 2'd2);
    go();
    wait_ev(0, 20, "t3_s0", r);
    wait_ev(0, 20, "t3_s1", r);
    chk("t3_second_strobe", 32'(r), 32'd8);
    repeat (2) @(negedge clk);
    pause = 1'b1;
    repeat (5) @(negedge clk);
    chk("t3_paused_note", 32'(note), 32'd0);
    chk("t3_paused_oct", 32'(octave), 32'd2);
    chk("t3_paused_idx", 32'(note_idx), 32'd1);
    repeat (5) @(negedge clk);
    pause = 1'b0;
    @(negedge clk);
    chk("t3_restored", 32'(note), 32'd1);
    wait_ev(0, 20, "t3_s2", r);
    chk("t3_delayed_strobe", 32'(r), 32'd25);
    do_stop();

    // Padding entries 0..5, real note at entry 6
    fill(4'd2, 4'd1, 2'd0);
    for (int i = 0; i < 6; i++) set_entry(i, 4'hF, 4'd2, 2'd0);
    set_entry(6, 4'd3, 4'd1, 2'd0);
    go();
`ifdef SEQ_SKIP_PAD_EN
    wait_ev(0, 20, "t5_s0", r);
    chk("t5_pad_strobe", 32'(r), 32'd7);
    chk("t5_pad_note", 32'(note), 32'd3);
    chk("t5_pad_idx", 32'(note_idx), 32'd6);
`else
    wait_ev(0, 20, "t5_s0", r);
    chk("t5_rest_strobe", 32'(r), 32'd1);
    chk("t5_rest_note", 32'(note), 32'd15);
    for (int i = 0; i < 6; i++) wait_ev(0, 20, "t5_sn", r);
    chk("t5_entry6_strobe", 32'(r), 32'd31);
    chk("t5_entry6_note", 32'(note), 32'd3);
    chk("t5_entry6_idx", 32'(note_idx), 32'd6);
`endif
    do_stop();

    // Snapshot: input change mid-song ignored, picked up on restart from DONE
    fill(4'd1, 4'd1, 2'd1);
    go();
    wait_ev(0, 20, "t6_s0", r);
    for (int i = 0; i < N; i++) song_packed[223-4*i -: 4] = 4'd7;
    wait_ev(0, 20, "t6_s1", r);
    chk("t6_second_strobe", 32'(r), 32'd4);
    chk("t6_old_note", 32'(note), 32'd1);
    wait_ev(1, 300, "t6_done", r);
    chk("t6_done_time", 32'(r), 32'd168);
    go();
    wait_ev(0, 20, "t6_s2", r);
    chk("t6_new_note", 32'(note), 32'd7);
    do_stop();

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
